// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Purpose  : Shared defaults for the switch debounce bank.
// Revision : 1.0
// ============================================================================
package debounce_pkg;

  // 20 ms at 12 MHz; counter width chosen so the limit fits without wrapping.
  localparam int unsigned c_default_limit = 240000;
  localparam int unsigned c_default_size  = 18;

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// Module   : debounce_chan
// Purpose  : One switch channel: 2-flop synchroniser, stability counter,
//            debounced level and registered rise/fall pulses.
// Revision : 1.0
// ============================================================================
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = c_default_limit,
  parameter int unsigned DEBOUNCE_SIZE  = c_default_size,
  parameter logic        INITIAL_STATE  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic switch_in,
  output logic switch_out,
  output logic rise,
  output logic fall
);

  localparam logic [DEBOUNCE_SIZE-1:0] c_last_count = DEBOUNCE_SIZE'(DEBOUNCE_LIMIT - 1);

  logic                     sync1_q, sync1_d;
  logic                     sync2_q, sync2_d;
  logic                     state_q, state_d;
  logic [DEBOUNCE_SIZE-1:0] count_q, count_d;
  logic                     rise_q, rise_d;
  logic                     fall_q, fall_d;

  always_comb begin
    sync1_d = switch_in;
    sync2_d = sync1_q;
    state_d = state_q;
    count_d = '0;
    // Any cycle agreeing with the current level restarts the stability count.
    if (sync2_q != state_q) begin
      if (count_q == c_last_count) begin
        state_d = sync2_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
    rise_d = state_d & ~state_q;
    fall_d = ~state_d & state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= INITIAL_STATE;
      sync2_q <= INITIAL_STATE;
      state_q <= INITIAL_STATE;
      count_q <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      count_q <= count_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign switch_out = state_q;
  assign rise       = rise_q;
  assign fall       = fall_q;

endmodule
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bank
// Purpose  : Bank of independent debounced switches with sticky change flags
//            and a combined interrupt.
// Revision : 1.0
// ============================================================================
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned         CHANNELS       = 4,
  parameter int unsigned         DEBOUNCE_LIMIT = c_default_limit,
  parameter int unsigned         DEBOUNCE_SIZE  = c_default_size,
  parameter logic [CHANNELS-1:0] INITIAL_STATE  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] switch_in,
  output logic [CHANNELS-1:0] switch_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  input  logic [CHANNELS-1:0] event_clr,
  output logic [CHANNELS-1:0] events,
  output logic                irq
);

  logic [CHANNELS-1:0] events_q, events_d;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      debounce_chan #(
        .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
        .DEBOUNCE_SIZE  (DEBOUNCE_SIZE),
        .INITIAL_STATE  (INITIAL_STATE[i])
      ) u_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .switch_in  (switch_in[i]),
        .switch_out (switch_out[i]),
        .rise       (rise[i]),
        .fall       (fall[i])
      );
    end
  endgenerate

  // A pulse arriving together with a clear keeps the flag set.
  always_comb begin
    events_d = (events_q & ~event_clr) | rise | fall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      events_q <= '0;
    end else begin
      events_q <= events_d;
    end
  end

  assign events = events_q;
  assign irq    = |events_q;

endmodule
`default_nettype wire
